packet_buffer: RTL and testbench
================================

Name: packet_buffer

Overview:
Ingress buffer for the packet-capture path. Accepts header-prefixed packets on a 64-bit AXI4-Stream slave and strips the one-word header. It stores payload words in an internal FIFO. Each payload word is fanned out as NUM_LANES independent byte-wide valid/ready lanes toward the downstream per-byte processing engines.

Parameters:
AXI_WIDTH, 64, input stream width in bits; must be a multiple of OUTPUT_WIDTH.
OUTPUT_WIDTH, 8, width of each output lane in bits.
FIFO_DEPTH, 16, payload word FIFO depth; must be a power of two and at least 2.
NUM_LANES, AXI_WIDTH/OUTPUT_WIDTH (8), derived localparam, not overridable.

Ports:
clk_i  in  1  single clock; all logic on the rising edge.
rst_i  in  1  synchronous, active-low reset (0 = reset).
tdata_i  in  AXI_WIDTH  stream data; byte 0 is in tdata_i[AXI_WIDTH-1 -: 8] (MSB-first).
tvalid_i  in  1  stream valid.
tlast_i  in  1  marks the last word of a packet.
tready_o  out  1  stream ready.
pkt_tdata_o  out  [NUM_LANES] x OUTPUT_WIDTH  lane i carries byte i of the head payload word.
pkt_tvalid_o  out  [NUM_LANES] x 1  per-lane valid.
pkt_tready_i  in  [NUM_LANES] x 1  per-lane ready.

Behaviour:
- Transfer rules: an input transfer occurs when tvalid_i && tready_o. Lane i transfers when pkt_tvalid_o[i] && pkt_tready_i[i].
- Header format (word 0 of every packet): byte 0 = packet_length[15:8], byte 1 = packet_length[7:0], byte 2 = interface_id, bytes 3..7 reserved and ignored. packet_length is the payload byte count, excluding the header.
- Input FSM states:
  - HDR: the accepted word is captured as the header. remaining <= packet_length. Next state is PAY, unless tlast_i=1, in which case the FSM stays in HDR and nothing is written.
  - PAY: each accepted word is written to the FIFO with cnt = min(remaining, NUM_LANES), then remaining -= cnt.
    - If remaining is already 0, the word is accepted and discarded (excess or padding).
    - If tlast_i=1, return to HDR.
  - A packet shorter than packet_length ends at tlast; the remainder is dropped.
- tready_o = !rst && !fifo_full. The header word and discarded words are always accepted; they still require tready_o=1.
- FIFO entry = {data, cnt}; cnt has width clog2(NUM_LANES)+1. Entries with cnt=0 are never written.
- Output latency: a word written at edge N is visible on the lanes after edge N, i.e. in cycle N+1.
- Head entry fan-out:
  - pkt_tdata_o[i] = byte i of the head data.
  - pkt_tvalid_o[i] = fifo_not_empty && (i < cnt) && !done[i].
  - done[i] is set when lane i transfers.
  - Padding bytes (i >= cnt) are never valid; their tdata is don't-care but driven to 0.
- Pop: the head entry is popped in the cycle where every lane i < cnt is either already done or transferring that cycle. On pop, done is cleared to 0. The next entry is presented the following cycle with no bubble.
- Simultaneous push and pop while full: push is refused, because tready_o is derived from the registered full flag. Push and pop in the same cycle when neither full nor empty: both happen and the count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are resolved with an extra pointer MSB.
- Reset (rst_i=0 at an edge) puts the design in this state the next cycle:
  - FIFO empty, done=0, state=HDR, remaining=0.
  - pkt_tvalid_o all 0, pkt_tdata_o all 0, tready_o=0 while rst_i=0.
  - A reset mid-packet discards all buffered data. The first word after reset is treated as a header.
- Lanes are independent: a stalled lane blocks the pop of the word, but other lanes that have already transferred stay low (done) and are not repeated.

Test Plan:
- Length-8 packet: header 0x0008_0A00_0000_0000, then payload 0x0011223344556677 with tlast → lanes 0..7 present 00,11,...,77 with all ready high. Exactly one transfer per lane, FIFO empty afterwards.
- Length-13 packet: header, then 2 payload words, zero-padded → second word asserts valid only on lanes 0..4. Lanes 5..7 stay low.
- Lane stall: pkt_tready_i[3]=0 for 5 cycles, other lanes ready → lanes ≠3 transfer once and drop valid. Lane 3 is held until ready, then the next word appears on the following cycle.
- Backpressure: all lanes held not-ready, stream 20 payload words → tready_o drops after 16 words are stored. Releasing the lanes drains them in order with no loss or duplication.
- Length mismatch: header length 4 with 2 payload words → only bytes 0..3 of word 1 are output. Word 2 is accepted and discarded. The next packet's header is parsed correctly.
- Mid-packet reset: assert rst_i=0 for 1 cycle after 3 payload words → all valids 0 and the FIFO empty. The next packet (header plus 1 word) is output correctly.

Source files
------------

// File: rtl/packet_buffer.sv
// Ingress packet buffer: strips the one-word header from each AXI4-Stream packet,
// queues payload words with their valid-byte count, and fans each word out as byte lanes.
module packet_buffer #(
  parameter  int AXI_WIDTH    = 64,
  parameter  int OUTPUT_WIDTH = 8,
  parameter  int FIFO_DEPTH   = 16,
  localparam int NUM_LANES    = AXI_WIDTH / OUTPUT_WIDTH
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [AXI_WIDTH-1:0]                    tdata_i,
  input  logic                                    tvalid_i,
  input  logic                                    tlast_i,
  output logic                                    tready_o,
  output logic [NUM_LANES-1:0][OUTPUT_WIDTH-1:0]  pkt_tdata_o,
  output logic [NUM_LANES-1:0]                    pkt_tvalid_o,
  input  logic [NUM_LANES-1:0]                    pkt_tready_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(NUM_LANES) + 1;

  typedef enum logic {HDR, PAY} state_t;

  state_t                   state_reg, state_next;
  logic [15:0]              remaining_reg, remaining_next;
  logic [AW:0]              wr_ptr_reg, rd_ptr_reg;
  logic [NUM_LANES-1:0]     done_reg, done_next;
  logic [AXI_WIDTH+CW-1:0]  mem [FIFO_DEPTH];

  logic                     full, empty, accept, push, pop;
  logic [CW-1:0]            push_cnt, head_cnt;
  logic [AXI_WIDTH-1:0]     head_data;
  logic [NUM_LANES-1:0]     lane_active, xfer;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign tready_o = rst_i && !full;
  assign accept   = tvalid_i && tready_o;

  // Header/payload parser; payload past the announced length is swallowed.
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    push           = 1'b0;
    push_cnt       = '0;
    if (accept) begin
      case (state_reg)
        HDR: begin
          remaining_next = tdata_i[AXI_WIDTH-1 -: 16];
          if (!tlast_i) state_next = PAY;
        end
        PAY: begin
          if (remaining_reg != 16'd0) begin
            push           = 1'b1;
            push_cnt       = (remaining_reg >= 16'(NUM_LANES)) ? CW'(NUM_LANES)
                                                               : remaining_reg[CW-1:0];
            remaining_next = remaining_reg - 16'(push_cnt);
          end
          if (tlast_i) state_next = HDR;
        end
        default: state_next = HDR;
      endcase
    end
  end

  assign {head_data, head_cnt} = mem[rd_ptr_reg[AW-1:0]];

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lane_active[gi]  = !empty && (CW'(gi) < head_cnt);
      assign pkt_tvalid_o[gi] = lane_active[gi] && !done_reg[gi];
      assign pkt_tdata_o[gi]  = lane_active[gi]
                                ? head_data[AXI_WIDTH-1-gi*OUTPUT_WIDTH -: OUTPUT_WIDTH]
                                : '0;
      assign xfer[gi]         = pkt_tvalid_o[gi] && pkt_tready_i[gi];
    end
  endgenerate

  // A word retires once every active lane has either finished or finishes now.
  assign pop       = !empty && (&(done_reg | xfer | ~lane_active));
  assign done_next = pop ? '0 : (done_reg | xfer);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg     <= HDR;
      remaining_reg <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      done_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      done_reg      <= done_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= {tdata_i, push_cnt};
  end

endmodule

// File: tb/tb_packet_buffer.sv
// Directed bench for packet_buffer: a per-cycle vector table plus hand-written
// sequences for lane stall, FIFO backpressure and mid-packet reset.
module tb_packet_buffer;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [63:0]     tdata;
  logic            tvalid, tlast, tready;
  logic [7:0][7:0] pkt_tdata;
  logic [7:0]      pkt_tvalid, pkt_tready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  packet_buffer #(.AXI_WIDTH(64), .OUTPUT_WIDTH(8), .FIFO_DEPTH(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .tdata_i(tdata), .tvalid_i(tvalid), .tlast_i(tlast),
    .tready_o(tready), .pkt_tdata_o(pkt_tdata), .pkt_tvalid_o(pkt_tvalid),
    .pkt_tready_i(pkt_tready)
  );

  typedef struct {
    logic [63:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        exp_tready;
    logic [7:0]  exp_valid;
    logic [63:0] exp_word;
  } vec_t;

  vec_t vecs [21];

  function automatic logic [7:0][7:0] lanes_of(input logic [63:0] w);
    logic [7:0][7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[63-8*i -: 8];
    return r;
  endfunction

  function automatic logic [63:0] word_of(input int k);
    return {56'h10_2030_4050_6070, 8'(k)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] d, input logic v, input logic l);
    tdata = d; tvalid = v; tlast = l;
    #1;
  endtask

  int acc, exp_idx;

  initial begin
    vecs[0]  = '{64'h0008_0A00_0000_0000, 1'b1, 1'b0, 1'b1, 8'h00, 64'h0};
    vecs[1]  = '{64'h0011_2233_4455_6677, 1'b1, 1'b1, 1'b1, 8'h00, 64'h0};
    vecs[2]  = '{64'h0,                   1'b0, 1'b0, 1'b1, 8'hFF, 64'h0011_2233_4455_6677};
    vecs[3]  = '{64'h0,                   1'b0, 1'b0, 1'b1, 8'h00, 64'h0};
    vecs[4]  = '{64'h000D_0100_0000_0000, 1'b1, 1'b0, 1'b1, 8'h00, 64'h0};
    vecs[5]  = '{64'h0102_0304_0506_0708, 1'b1, 1'b0, 1'b1, 8'h00, 64'h0};
    vecs[6]  = '{64'h1112_1314_1516_1718, 1'b1, 1'b1, 1'b1, 8'hFF, 64'h0102_0304_0506_0708};
    vecs[7]  = '{64'h0,                   1'b0, 1'b0, 1'b1, 8'h1F, 64'h1112_1314_1500_0000};
    vecs[8]  = '{64'h0,                   1'b0, 1'b0, 1'b1, 8'h00, 64'h0};
    vecs[9]  = '{64'h0004_0200_0000_0000, 1'b1, 1'b0, 1'b1, 8'h00, 64'h0};
    vecs[10] = '{64'hA1A2_A3A4_A5A6_A7A8, 1'b1, 1'b0, 1'b1, 8'h00, 64'h0};
    vecs[11] = '{64'hB1B2_B3B4_B5B6_B7B8, 1'b1, 1'b1, 1'b1, 8'h0F, 64'hA1A2_A3A4_0000_0000};
    vecs[12] = '{64'h0008_0300_0000_0000, 1'b1, 1'b0, 1'b1, 8'h00, 64'h0};
    vecs[13] = '{64'hC1C2_C3C4_C5C6_C7C8, 1'b1, 1'b1, 1'b1, 8'h00, 64'h0};
    vecs[14] = '{64'h0,                   1'b0, 1'b0, 1'b1, 8'hFF, 64'hC1C2_C3C4_C5C6_C7C8};
    vecs[15] = '{64'h0,                   1'b0, 1'b0, 1'b1, 8'h00, 64'h0};
    vecs[16] = '{64'h0008_0000_0000_0000, 1'b1, 1'b1, 1'b1, 8'h00, 64'h0};
    vecs[17] = '{64'h0001_0000_0000_0000, 1'b1, 1'b0, 1'b1, 8'h00, 64'h0};
    vecs[18] = '{64'hD1D2_D3D4_D5D6_D7D8, 1'b1, 1'b1, 1'b1, 8'h00, 64'h0};
    vecs[19] = '{64'h0,                   1'b0, 1'b0, 1'b1, 8'h01, 64'hD100_0000_0000_0000};
    vecs[20] = '{64'h0,                   1'b0, 1'b0, 1'b1, 8'h00, 64'h0};

    // Reset
    rst_i = 1'b0; tdata = '0; tvalid = 1'b0; tlast = 1'b0; pkt_tready = '1;
    tick(); tick();
    #1;
    chk("reset tready", 64'(tready), 64'd0);
    rst_i = 1'b1;
    #1;
    chk("post-reset tready", 64'(tready), 64'd1);
    chk("post-reset valid", 64'(pkt_tvalid), 64'h0);
    chk("post-reset data", 64'(pkt_tdata), 64'h0);
    tick();

    // Table: length 8, length 13, length mismatch, header-only packet
    for (int k = 0; k < 21; k++) begin
      drive(vecs[k].tdata, vecs[k].tvalid, vecs[k].tlast);
      chk($sformatf("vec%0d tready", k), 64'(tready), 64'(vecs[k].exp_tready));
      chk($sformatf("vec%0d valid", k), 64'(pkt_tvalid), 64'(vecs[k].exp_valid));
      chk($sformatf("vec%0d data", k), 64'(pkt_tdata), 64'(lanes_of(vecs[k].exp_word)));
      $display("vec %0d: tdata=%h valid=%h lanes=%h", k, vecs[k].tdata, pkt_tvalid, pkt_tdata);
      tick();
    end

    // Lane 3 stalled for 5 cycles
    drive(64'h0010_0000_0000_0000, 1'b1, 1'b0); tick();
    pkt_tready = 8'hF7;
    drive(64'h3132_3334_3536_3738, 1'b1, 1'b0); tick();
    drive(64'h4142_4344_4546_4748, 1'b1, 1'b1);
    chk("stall first valid", 64'(pkt_tvalid), 64'hFF);
    tick();
    drive(64'h0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("stall c%0d valid", c), 64'(pkt_tvalid), 64'h08);
      chk($sformatf("stall c%0d lane3", c), 64'(pkt_tdata[3]), 64'h34);
      $display("stall cycle %0d: valid=%h", c, pkt_tvalid);
      tick();
    end
    pkt_tready = 8'hFF;
    #1;
    chk("stall release valid", 64'(pkt_tvalid), 64'h08);
    tick();
    chk("stall next valid", 64'(pkt_tvalid), 64'hFF);
    chk("stall next data", 64'(pkt_tdata), 64'(lanes_of(64'h4142_4344_4546_4748)));
    tick();
    chk("stall drained", 64'(pkt_tvalid), 64'h0);

    // Backpressure: 20 words into a 16-deep FIFO
    pkt_tready = 8'h00;
    drive(64'h00A0_0000_0000_0000, 1'b1, 1'b0); tick();
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      drive(word_of(acc), 1'b1, acc == 19);
      if (tready) acc++;
      tick();
    end
    drive(word_of(acc), 1'b1, acc == 19);
    chk("bp accepted", 64'(acc), 64'd16);
    chk("bp tready full", 64'(tready), 64'd0);
    pkt_tready = 8'hFF;
    exp_idx = 0;
    for (int c = 0; c < 80 && exp_idx < 20; c++) begin
      if (acc < 20) drive(word_of(acc), 1'b1, acc == 19);
      else          drive(64'h0, 1'b0, 1'b0);
      if (pkt_tvalid == 8'hFF) begin
        chk($sformatf("drain word%0d", exp_idx), 64'(pkt_tdata), 64'(lanes_of(word_of(exp_idx))));
        $display("drain %0d: lanes=%h", exp_idx, pkt_tdata);
        exp_idx++;
      end else begin
        chk("drain partial valid", 64'(pkt_tvalid), 64'h0);
      end
      if (tvalid && tready) acc++;
      tick();
    end
    chk("drain count", 64'(exp_idx), 64'd20);
    chk("drain accepted", 64'(acc), 64'd20);
    drive(64'h0, 1'b0, 1'b0);
    chk("drain empty", 64'(pkt_tvalid), 64'h0);
    tick();

    // Mid-packet reset after 3 buffered payload words
    pkt_tready = 8'h00;
    drive(64'h0040_0000_0000_0000, 1'b1, 1'b0); tick();
    for (int c = 0; c < 3; c++) begin
      drive(64'hE0E0_E0E0_E0E0_E000 | 64'(c), 1'b1, 1'b0);
      tick();
    end
    drive(64'h0, 1'b0, 1'b0);
    chk("pre-reset valid", 64'(pkt_tvalid), 64'hFF);
    rst_i = 1'b0;
    #1;
    chk("mid-reset tready", 64'(tready), 64'd0);
    tick();
    rst_i = 1'b1;
    #1;
    chk("after reset valid", 64'(pkt_tvalid), 64'h0);
    chk("after reset data", 64'(pkt_tdata), 64'h0);
    chk("after reset tready", 64'(tready), 64'd1);
    drive(64'h0008_0500_0000_0000, 1'b1, 1'b0); tick();
    pkt_tready = 8'hFF;
    drive(64'hF1F2_F3F4_F5F6_F7F8, 1'b1, 1'b1);
    chk("reset pkt hdr valid", 64'(pkt_tvalid), 64'h0);
    tick();
    drive(64'h0, 1'b0, 1'b0);
    chk("reset pkt valid", 64'(pkt_tvalid), 64'hFF);
    chk("reset pkt data", 64'(pkt_tdata), 64'(lanes_of(64'hF1F2_F3F4_F5F6_F7F8)));
    $display("reset pkt: lanes=%h", pkt_tdata);
    tick();
    chk("reset pkt drained", 64'(pkt_tvalid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
